// File: rtl/div_unit.sv
// Sequential signed 32-bit restoring divider for the MIPS div instruction.
// lo = quotient, hi = remainder; 33 cycles accept-to-done, 1 cycle on divide-by-zero.
module div_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        div_zero
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t      state;
    state_t      next_state;
    logic        sign_q;
    logic        sign_r;
    logic [31:0] mag_b;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [5:0]  cnt;
    logic [32:0] shifted;
    logic [32:0] trial;
    logic        b_zero;

    assign b_zero = (b == 32'd0);

    // rem < |b| always holds, so the 33rd remainder bit only exists inside the trial.
    assign shifted = {rem, quo[31]};
    assign trial   = shifted - {1'b0, mag_b};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = b_zero ? DONE : CALC;
                end
            end
            CALC: begin
                if (cnt == 6'd31) begin
                    next_state = FIX;
                end
            end
            FIX:     next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hi       <= 32'd0;
            lo       <= 32'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
            mag_b    <= 32'd0;
            quo      <= 32'd0;
            rem      <= 32'd0;
            cnt      <= 6'd0;
        end else begin
            busy <= (next_state != IDLE);
            done <= (next_state == DONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        sign_q   <= a[31] ^ b[31];
                        sign_r   <= a[31];
                        quo      <= a[31] ? -a : a;
                        mag_b    <= b[31] ? -b : b;
                        rem      <= 32'd0;
                        cnt      <= 6'd0;
                        div_zero <= b_zero;
                    end
                end
                CALC: begin
                    cnt <= cnt + 6'd1;
                    if (!trial[32]) begin
                        rem <= trial[31:0];
                        quo <= {quo[30:0], 1'b1};
                    end else begin
                        rem <= shifted[31:0];
                        quo <= {quo[30:0], 1'b0};
                    end
                end
                FIX: begin
                    lo <= sign_q ? -quo : quo;
                    hi <= sign_r ? -rem : rem;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: vector table plus hand sequences for
// divide-by-zero, ignored start pulses and mid-operation reset.
module tb_div_unit;

    logic        clock;
    logic        reset;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        div_zero;

    int total = 0;
    int bad   = 0;

    div_unit dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .a        (a),
        .b        (b),
        .hi       (hi),
        .lo       (lo),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] lo;
        logic [31:0] hi;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Issues one request, optionally re-pulses start (with 1/1) after inj edges,
    // then checks results, the edge count to done, busy, and the return to IDLE.
    // A start held during the DONE cycle must be ignored as well.
    task automatic do_vec(input string nm, input logic [31:0] av, input logic [31:0] bv,
                          input logic [31:0] elo, input logic [31:0] ehi, input logic edz,
                          input int ek, input int inj);
        int   k;
        logic busy_ok;
        @(negedge clock);
        a = av;
        b = bv;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        a = 32'hdead_beef;
        b = 32'd0;
        k = 0;
        busy_ok = 1'b1;
        @(negedge clock);
        while (!done && k < 100) begin
            if (!busy) busy_ok = 1'b0;
            if (k == inj) begin
                start = 1'b1;
                a = 32'd1;
                b = 32'd1;
            end else begin
                start = 1'b0;
            end
            @(posedge clock);
            k++;
            @(negedge clock);
        end
        start = 1'b0;
        if (k >= 100) k = -1;
        if (!busy) busy_ok = 1'b0;
        chk({nm, " done_edge"}, k, ek);
        chk({nm, " lo"}, lo, elo);
        chk({nm, " hi"}, hi, ehi);
        chk({nm, " div_zero"}, {31'd0, div_zero}, {31'd0, edz});
        chk({nm, " busy_held"}, {31'd0, busy_ok}, 32'd1);
        start = 1'b1;
        a = 32'd1;
        b = 32'd1;
        @(posedge clock);
        #1;
        start = 1'b0;
        @(negedge clock);
        chk({nm, " idle_after"}, {30'd0, busy, done}, 32'd0);
    endtask

    vec_t vt[12];

    initial begin
        vt[0]  = '{32'd7,         32'd2,         32'd3,         32'd1};
        vt[1]  = '{32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD,  32'hFFFFFFFF};
        vt[2]  = '{32'd7,         32'hFFFFFFFE,  32'hFFFFFFFD,  32'd1};
        vt[3]  = '{32'hFFFFFFF9,  32'hFFFFFFFE,  32'd3,         32'hFFFFFFFF};
        vt[4]  = '{32'h80000000,  32'hFFFFFFFF,  32'h80000000,  32'd0};
        vt[5]  = '{32'hFFFFFF9C,  32'd7,         32'hFFFFFFF2,  32'hFFFFFFFE};
        vt[6]  = '{32'h7FFFFFFF,  32'd1,         32'h7FFFFFFF,  32'd0};
        vt[7]  = '{32'h80000000,  32'd2,         32'hC0000000,  32'd0};
        vt[8]  = '{32'd1,         32'h80000000,  32'd0,         32'd1};
        vt[9]  = '{32'h80000000,  32'h80000000,  32'd1,         32'd0};
        vt[10] = '{32'hFFFFFFFB,  32'd7,         32'd0,         32'hFFFFFFFB};
        vt[11] = '{32'd7,         32'd2,         32'd3,         32'd1};

        reset = 1'b0;
        start = 1'b0;
        a = 32'd0;
        b = 32'd0;
        #23;
        chk("reset hi", hi, 32'd0);
        chk("reset lo", lo, 32'd0);
        chk("reset flags", {29'd0, busy, done, div_zero}, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("post_reset flags", {29'd0, busy, done, div_zero}, 32'd0);

        for (int i = 0; i < 12; i++) begin
            do_vec($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].lo, vt[i].hi, 1'b0, 33, -1);
        end

        // vt[11] left hi=1, lo=3; a zero divisor must keep them.
        do_vec("divzero", 32'd5, 32'd0, 32'd3, 32'd1, 1'b1, 0, -1);

        do_vec("ignored_start", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33, 10);

        @(negedge clock);
        a = 32'd100;
        b = 32'd7;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (15) @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        chk("midreset hi", hi, 32'd0);
        chk("midreset lo", lo, 32'd0);
        chk("midreset flags", {29'd0, busy, done, div_zero}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("midreset no_done", {31'd0, done}, 32'd0);
        end
        reset = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            chk("after_reset idle", {30'd0, busy, done}, 32'd0);
        end
        do_vec("after_reset", 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 33, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
